// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: ALU function codes, opcodes, FSM state
// and the decoded control word.
package alu_seq_pkg;

  localparam int DW = 8;
  localparam int FW = 4;

  localparam logic [3:0] ALUS_CLR  = 4'd0;
  localparam logic [3:0] ALUS_ADD  = 4'd1;
  localparam logic [3:0] ALUS_SUB  = 4'd2;
  localparam logic [3:0] ALUS_AND  = 4'd3;
  localparam logic [3:0] ALUS_OR   = 4'd4;
  localparam logic [3:0] ALUS_XOR  = 4'd5;
  localparam logic [3:0] ALUS_INC  = 4'd6;
  localparam logic [3:0] ALUS_DEC  = 4'd7;
  localparam logic [3:0] ALUS_SHR  = 4'd8;
  localparam logic [3:0] ALUS_PASS = 4'd9;
  localparam logic [3:0] ALUS_NEG  = 4'd10;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDX  = 4'd1;
  localparam logic [3:0] OP_LDA  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_INCA = 4'd8;
  localparam logic [3:0] OP_DECA = 4'd9;
  localparam logic [3:0] OP_SHRA = 4'd10;
  localparam logic [3:0] OP_NEGA = 4'd11;
  localparam logic [3:0] OP_CLRA = 4'd12;
  localparam logic [3:0] OP_ADDI = 4'd13;
  localparam logic [3:0] OP_SUBI = 4'd14;
  localparam logic [3:0] OP_STA  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
  typedef enum logic [1:0] {XS_ZERO, XS_A, XS_X, XS_IMM} xsel_t;
  typedef enum logic [1:0] {BS_ZERO, BS_A, BS_IMM} bsel_t;
  typedef enum logic [1:0] {DST_NONE, DST_A, DST_X} dst_t;

  typedef struct packed {
    logic [FW-1:0] alus;
    xsel_t         xsel;
    bsel_t         bsel;
    dst_t          dst;
    logic          store;
  } dec_t;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction handshake and result/completion signals between controller and sequencer.
interface alu_seq_if;
  logic       ins_valid;
  logic       ins_ready;
  logic [3:0] ins_op;
  logic [7:0] ins_imm;
  logic       res_valid;
  logic [7:0] res_data;
  logic       done;

  modport master (output ins_valid, ins_op, ins_imm,
                  input  ins_ready, res_valid, res_data, done);
  modport slave  (input  ins_valid, ins_op, ins_imm,
                  output ins_ready, res_valid, res_data, done);
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational opcode decode: ALU function, operand selects, destination, store flag.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '{alus: ALUS_CLR, xsel: XS_ZERO, bsel: BS_ZERO, dst: DST_NONE, store: 1'b0};
    case (op)
      OP_LDX:  dec = '{ALUS_PASS, XS_ZERO, BS_IMM,  DST_X,    1'b0};
      OP_LDA:  dec = '{ALUS_PASS, XS_ZERO, BS_IMM,  DST_A,    1'b0};
      OP_ADD:  dec = '{ALUS_ADD,  XS_X,    BS_A,    DST_A,    1'b0};
      OP_SUB:  dec = '{ALUS_SUB,  XS_X,    BS_A,    DST_A,    1'b0};
      OP_AND:  dec = '{ALUS_AND,  XS_X,    BS_A,    DST_A,    1'b0};
      OP_OR:   dec = '{ALUS_OR,   XS_X,    BS_A,    DST_A,    1'b0};
      OP_XOR:  dec = '{ALUS_XOR,  XS_X,    BS_A,    DST_A,    1'b0};
      OP_INCA: dec = '{ALUS_INC,  XS_A,    BS_ZERO, DST_A,    1'b0};
      OP_DECA: dec = '{ALUS_DEC,  XS_A,    BS_ZERO, DST_A,    1'b0};
      OP_SHRA: dec = '{ALUS_SHR,  XS_A,    BS_ZERO, DST_A,    1'b0};
      OP_NEGA: dec = '{ALUS_NEG,  XS_A,    BS_ZERO, DST_A,    1'b0};
      OP_CLRA: dec = '{ALUS_CLR,  XS_ZERO, BS_ZERO, DST_A,    1'b0};
      OP_ADDI: dec = '{ALUS_ADD,  XS_A,    BS_IMM,  DST_A,    1'b0};
      OP_SUBI: dec = '{ALUS_SUB,  XS_IMM,  BS_A,    DST_A,    1'b0};
      OP_STA:  dec = '{ALUS_CLR,  XS_ZERO, BS_ZERO, DST_NONE, 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator-style sequencer driving an external 8-bit ALU (IDLE -> EXEC -> WB).
// Optional carry flag enabled by defining ALU_SEQ_CARRY_EN.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_if.slave      ins,
  output logic [FW-1:0] alus,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_bus,
  input  logic [DW-1:0] alu_dout,
  output logic [DW-1:0] acc,
  output logic [DW-1:0] xreg,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c
);

  state_t        state;
  dec_t          dec, dec_q;
  logic [DW-1:0] x_nxt, bus_nxt;
  logic          done_r, res_valid_r;
  logic [DW-1:0] res_data_r;

  alu_seq_decode u_dec (.op(ins.ins_op), .dec(dec));

  // Operands are sampled at acceptance so EXEC drives pre-write A/X.
  always_comb begin
    x_nxt = '0;
    case (dec.xsel)
      XS_A:    x_nxt = acc;
      XS_X:    x_nxt = xreg;
      XS_IMM:  x_nxt = ins.ins_imm;
      default: x_nxt = '0;
    endcase
    bus_nxt = '0;
    case (dec.bsel)
      BS_A:    bus_nxt = acc;
      BS_IMM:  bus_nxt = ins.ins_imm;
      default: bus_nxt = '0;
    endcase
  end

  assign ins.ins_ready = (state == S_IDLE);
  assign ins.done      = done_r;
  assign ins.res_valid = res_valid_r;
  assign ins.res_data  = res_data_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dec_q       <= '{alus: ALUS_CLR, xsel: XS_ZERO, bsel: BS_ZERO, dst: DST_NONE, store: 1'b0};
      alus        <= '0;
      alu_x       <= '0;
      alu_bus     <= '0;
      acc         <= '0;
      xreg        <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      done_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ins.ins_valid) begin
            dec_q   <= dec;
            alus    <= dec.alus;
            alu_x   <= x_nxt;
            alu_bus <= bus_nxt;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          alus    <= '0;
          alu_x   <= '0;
          alu_bus <= '0;
          if (dec_q.dst == DST_A) acc  <= alu_dout;
          if (dec_q.dst == DST_X) xreg <= alu_dout;
          if (dec_q.dst != DST_NONE) begin
            flag_z <= (alu_dout == '0);
            flag_n <= alu_dout[DW-1];
          end
          if (dec_q.store) res_data_r <= acc;
          res_valid_r <= dec_q.store;
          done_r      <= 1'b1;
          state       <= S_WB;
        end
        default: begin
          done_r      <= 1'b0;
          res_valid_r <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_CARRY_EN
  logic [DW:0] sum9;
  logic        carry_nxt;

  // Carry/borrow derived from the driven operands, independent of the ALU result.
  always_comb begin
    sum9      = {1'b0, alu_bus} + {1'b0, alu_x};
    carry_nxt = 1'b0;
    case (alus)
      ALUS_ADD: carry_nxt = sum9[DW];
      ALUS_SUB: carry_nxt = (alu_bus < alu_x);
      ALUS_INC: carry_nxt = (alu_x == '1);
      ALUS_DEC: carry_nxt = (alu_x == '0);
      default:  carry_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flag_c <= 1'b0;
    else if (state == S_EXEC && dec_q.dst != DST_NONE)
      flag_c <= carry_nxt;
  end
`else
  assign flag_c = 1'b0;
`endif

endmodule
